reservation_station: RTL and testbench

- Consumer end of the decoder issue interface for ALU-class instructions (LUI, AUIPC, JAL, JALR, register-register, register-immediate, branch).
- Buffers each issued entry and snoops the ALU and LSB result broadcasts to resolve ROB-tag dependencies.
- Dispatches one operand-ready entry per cycle to the ALU through a registered interface.
- Produces rs_full, which feeds the decoder stall.

---
 rtl/reservation_station_pkg.sv | 45 ++++
 rtl/reservation_station_select_enc.sv | 23 ++
 rtl/reservation_station.sv | 220 ++++++++++++++++++++++
 tb/tb_reservation_station.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared widths, operation codes and boolean constants for the ALU reservation station.
package reservation_station_pkg;

  localparam int unsigned RS_SIZE_DEF   = 16;
  localparam int unsigned ROB_IDX_W_DEF = 4;
  localparam int unsigned OP_W_DEF      = 6;
  localparam int unsigned DATA_W_DEF    = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [OP_W_DEF-1:0] {
    OPENUM_NOP   = 6'd0,
    OPENUM_LUI,
    OPENUM_AUIPC,
    OPENUM_JAL,
    OPENUM_JALR,
    OPENUM_BEQ,
    OPENUM_BNE,
    OPENUM_BLT,
    OPENUM_BGE,
    OPENUM_BLTU,
    OPENUM_BGEU,
    OPENUM_ADD,
    OPENUM_SUB,
    OPENUM_SLL,
    OPENUM_SLT,
    OPENUM_SLTU,
    OPENUM_XOR,
    OPENUM_SRL,
    OPENUM_SRA,
    OPENUM_OR,
    OPENUM_AND,
    OPENUM_ADDI,
    OPENUM_SLTI,
    OPENUM_SLTIU,
    OPENUM_XORI,
    OPENUM_ORI,
    OPENUM_ANDI,
    OPENUM_SLLI,
    OPENUM_SRLI,
    OPENUM_SRAI
  } op_e;

endpackage

// File: rtl/reservation_station_select_enc.sv
// Lowest-set-bit priority encoder: reports whether any request is set and the index of the lowest one.
module rs_select_enc #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Scan upward and latch the first set bit.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers issued entries, wakes operands from ALU/LSB broadcasts,
// and dispatches the lowest-index ready entry to the ALU through registered outputs.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE   = RS_SIZE_DEF,
  parameter int unsigned ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int unsigned OP_W      = OP_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clr_in,
  input  logic                 issue_rs_ready,
  input  logic [ROB_IDX_W-1:0] issue_rob_index,
  input  logic [OP_W-1:0]      issue_op,
  input  logic [DATA_W-1:0]    issue_rs1_val,
  input  logic [DATA_W-1:0]    issue_rs2_val,
  input  logic [ROB_IDX_W-1:0] issue_rs1_depend,
  input  logic [ROB_IDX_W-1:0] issue_rs2_depend,
  input  logic [DATA_W-1:0]    issue_imm,
  input  logic [DATA_W-1:0]    issue_PC,
  input  logic                 issue_pred_br,
  input  logic                 alu_ready,
  input  logic [ROB_IDX_W-1:0] alu_rob_index,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 lsb_ready,
  input  logic [ROB_IDX_W-1:0] lsb_rob_index,
  input  logic [DATA_W-1:0]    lsb_result,
  output logic                 rs_full,
  output logic                 rs_to_alu_en,
  output logic [OP_W-1:0]      rs_to_alu_op,
  output logic [DATA_W-1:0]    rs_to_alu_rs1_val,
  output logic [DATA_W-1:0]    rs_to_alu_rs2_val,
  output logic [DATA_W-1:0]    rs_to_alu_imm,
  output logic [DATA_W-1:0]    rs_to_alu_PC,
  output logic [ROB_IDX_W-1:0] rs_to_alu_rob_index,
  output logic                 rs_to_alu_pred_br
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0]   ent_valid;
  logic [RS_SIZE-1:0]   ent_pred_br;
  logic [OP_W-1:0]      ent_op      [RS_SIZE];
  logic [DATA_W-1:0]    ent_rs1_val [RS_SIZE];
  logic [DATA_W-1:0]    ent_rs2_val [RS_SIZE];
  logic [ROB_IDX_W-1:0] ent_rs1_dep [RS_SIZE];
  logic [ROB_IDX_W-1:0] ent_rs2_dep [RS_SIZE];
  logic [DATA_W-1:0]    ent_imm     [RS_SIZE];
  logic [DATA_W-1:0]    ent_pc      [RS_SIZE];
  logic [ROB_IDX_W-1:0] ent_rob     [RS_SIZE];

  logic [CNT_W-1:0]     count;
  logic [RS_SIZE-1:0]   free_vec;
  logic [RS_SIZE-1:0]   ready_vec;
  logic                 free_found;
  logic                 sel_found;
  logic [IDX_W-1:0]     free_idx;
  logic [IDX_W-1:0]     sel_idx;
  logic                 do_insert;
  logic                 do_dispatch;

  logic [DATA_W-1:0]    in_rs1_val;
  logic [DATA_W-1:0]    in_rs2_val;
  logic [ROB_IDX_W-1:0] in_rs1_dep;
  logic [ROB_IDX_W-1:0] in_rs2_dep;

  assign rs_full     = (count >= CNT_W'(RS_SIZE - 1));
  assign do_insert   = issue_rs_ready && free_found;
  assign do_dispatch = sel_found;

  // Free and ready maps from the pre-edge entry state.
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      free_vec[i]  = ~ent_valid[i];
      ready_vec[i] = ent_valid[i] && (ent_rs1_dep[i] == '0) && (ent_rs2_dep[i] == '0);
    end
  end

  rs_select_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_enc (
    .req   (free_vec),
    .found (free_found),
    .index (free_idx)
  );

  rs_select_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_enc (
    .req   (ready_vec),
    .found (sel_found),
    .index (sel_idx)
  );

  // Resolve incoming operands against same-cycle broadcasts; ALU wins over LSB.
  always_comb begin
    in_rs1_val = issue_rs1_val;
    in_rs1_dep = issue_rs1_depend;
    in_rs2_val = issue_rs2_val;
    in_rs2_dep = issue_rs2_depend;
    if (issue_rs1_depend != '0) begin
      if (alu_ready && issue_rs1_depend == alu_rob_index) begin
        in_rs1_val = alu_result;
        in_rs1_dep = '0;
      end else if (lsb_ready && issue_rs1_depend == lsb_rob_index) begin
        in_rs1_val = lsb_result;
        in_rs1_dep = '0;
      end
    end
    if (issue_rs2_depend != '0) begin
      if (alu_ready && issue_rs2_depend == alu_rob_index) begin
        in_rs2_val = alu_result;
        in_rs2_dep = '0;
      end else if (lsb_ready && issue_rs2_depend == lsb_rob_index) begin
        in_rs2_val = lsb_result;
        in_rs2_dep = '0;
      end
    end
  end

  // Entry storage: wakeup, free on dispatch, insert into lowest free slot.
  // Insert targets a pre-edge free slot and dispatch a pre-edge valid one, so they never collide.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ent_valid   <= '0;
      ent_pred_br <= '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        ent_op[i]      <= '0;
        ent_rs1_val[i] <= '0;
        ent_rs2_val[i] <= '0;
        ent_rs1_dep[i] <= '0;
        ent_rs2_dep[i] <= '0;
        ent_imm[i]     <= '0;
        ent_pc[i]      <= '0;
        ent_rob[i]     <= '0;
      end
    end else if (clr_in) begin
      ent_valid <= '0;
    end else if (rdy_in) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (ent_valid[i]) begin
          if (ent_rs1_dep[i] != '0) begin
            if (alu_ready && ent_rs1_dep[i] == alu_rob_index) begin
              ent_rs1_val[i] <= alu_result;
              ent_rs1_dep[i] <= '0;
            end else if (lsb_ready && ent_rs1_dep[i] == lsb_rob_index) begin
              ent_rs1_val[i] <= lsb_result;
              ent_rs1_dep[i] <= '0;
            end
          end
          if (ent_rs2_dep[i] != '0) begin
            if (alu_ready && ent_rs2_dep[i] == alu_rob_index) begin
              ent_rs2_val[i] <= alu_result;
              ent_rs2_dep[i] <= '0;
            end else if (lsb_ready && ent_rs2_dep[i] == lsb_rob_index) begin
              ent_rs2_val[i] <= lsb_result;
              ent_rs2_dep[i] <= '0;
            end
          end
        end
      end
      if (do_dispatch) begin
        ent_valid[sel_idx] <= 1'b0;
      end
      if (do_insert) begin
        ent_valid[free_idx]   <= 1'b1;
        ent_op[free_idx]      <= issue_op;
        ent_rs1_val[free_idx] <= in_rs1_val;
        ent_rs1_dep[free_idx] <= in_rs1_dep;
        ent_rs2_val[free_idx] <= in_rs2_val;
        ent_rs2_dep[free_idx] <= in_rs2_dep;
        ent_imm[free_idx]     <= issue_imm;
        ent_pc[free_idx]      <= issue_PC;
        ent_rob[free_idx]     <= issue_rob_index;
        ent_pred_br[free_idx] <= issue_pred_br;
      end
    end
  end

  // Occupancy count: inserts minus dispatches.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (clr_in) begin
      count <= '0;
    end else if (rdy_in) begin
      count <= count + CNT_W'(do_insert) - CNT_W'(do_dispatch);
    end
  end

  // Registered dispatch port; data holds when nothing is selected.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rs_to_alu_en        <= FALSE;
      rs_to_alu_op        <= '0;
      rs_to_alu_rs1_val   <= '0;
      rs_to_alu_rs2_val   <= '0;
      rs_to_alu_imm       <= '0;
      rs_to_alu_PC        <= '0;
      rs_to_alu_rob_index <= '0;
      rs_to_alu_pred_br   <= FALSE;
    end else if (clr_in) begin
      rs_to_alu_en <= FALSE;
    end else if (rdy_in) begin
      rs_to_alu_en <= do_dispatch;
      if (do_dispatch) begin
        rs_to_alu_op        <= ent_op[sel_idx];
        rs_to_alu_rs1_val   <= ent_rs1_val[sel_idx];
        rs_to_alu_rs2_val   <= ent_rs2_val[sel_idx];
        rs_to_alu_imm       <= ent_imm[sel_idx];
        rs_to_alu_PC        <= ent_pc[sel_idx];
        rs_to_alu_rob_index <= ent_rob[sel_idx];
        rs_to_alu_pred_br   <= ent_pred_br[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with a slot-array reference model and per-cycle compare.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int RS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy = 1'b1;
  logic        clr = 1'b0;
  logic        iss = 1'b0;
  logic [3:0]  iss_rob = '0;
  logic [5:0]  iss_op = '0;
  logic [31:0] iss_v1 = '0, iss_v2 = '0, iss_imm = '0, iss_pc = '0;
  logic [3:0]  iss_d1 = '0, iss_d2 = '0;
  logic        iss_pbr = 1'b0;
  logic        alu_rdy = 1'b0, lsb_rdy = 1'b0;
  logic [3:0]  alu_tag = '0, lsb_tag = '0;
  logic [31:0] alu_res = '0, lsb_res = '0;

  logic        d_full, d_en, d_pbr;
  logic [5:0]  d_op;
  logic [31:0] d_v1, d_v2, d_imm, d_pc;
  logic [3:0]  d_rob;

  reservation_station #(.RS_SIZE(16), .ROB_IDX_W(4), .OP_W(6), .DATA_W(32)) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .rdy_in              (rdy),
    .clr_in              (clr),
    .issue_rs_ready      (iss),
    .issue_rob_index     (iss_rob),
    .issue_op            (iss_op),
    .issue_rs1_val       (iss_v1),
    .issue_rs2_val       (iss_v2),
    .issue_rs1_depend    (iss_d1),
    .issue_rs2_depend    (iss_d2),
    .issue_imm           (iss_imm),
    .issue_PC            (iss_pc),
    .issue_pred_br       (iss_pbr),
    .alu_ready           (alu_rdy),
    .alu_rob_index       (alu_tag),
    .alu_result          (alu_res),
    .lsb_ready           (lsb_rdy),
    .lsb_rob_index       (lsb_tag),
    .lsb_result          (lsb_res),
    .rs_full             (d_full),
    .rs_to_alu_en        (d_en),
    .rs_to_alu_op        (d_op),
    .rs_to_alu_rs1_val   (d_v1),
    .rs_to_alu_rs2_val   (d_v2),
    .rs_to_alu_imm       (d_imm),
    .rs_to_alu_PC        (d_pc),
    .rs_to_alu_rob_index (d_rob),
    .rs_to_alu_pred_br   (d_pbr)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit run     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: a plain slot array plus the last dispatched record.
  typedef struct {
    bit          valid;
    logic [5:0]  op;
    logic [31:0] v1, v2, imm, pc;
    logic [3:0]  d1, d2, rob;
    bit          pbr;
  } ent_t;

  ent_t        m [RS];
  bit          m_en;
  logic [5:0]  m_op;
  logic [31:0] m_v1, m_v2, m_imm, m_pc;
  logic [3:0]  m_rob;
  bit          m_pbr;

  function automatic int occupancy();
    int n = 0;
    for (int i = 0; i < RS; i++) if (m[i].valid) n++;
    return n;
  endfunction

  task automatic resolve(input logic [3:0] d, input logic [31:0] v,
                         output logic [3:0] d_o, output logic [31:0] v_o);
    d_o = d;
    v_o = v;
    if (d != 4'd0) begin
      if (alu_rdy && d == alu_tag) begin
        d_o = 4'd0;
        v_o = alu_res;
      end else if (lsb_rdy && d == lsb_tag) begin
        d_o = 4'd0;
        v_o = lsb_res;
      end
    end
  endtask

  task automatic model_edge();
    ent_t pre [RS];
    ent_t nx  [RS];
    int sel = -1;
    int fr  = -1;
    logic [3:0]  td;
    logic [31:0] tv;
    pre = m;
    nx  = m;
    if (clr) begin
      for (int i = 0; i < RS; i++) nx[i].valid = 1'b0;
      m    <= nx;
      m_en <= 1'b0;
      return;
    end
    if (!rdy) return;
    for (int i = 0; i < RS; i++) begin
      if (sel < 0 && pre[i].valid && pre[i].d1 == 4'd0 && pre[i].d2 == 4'd0) sel = i;
      if (fr < 0 && !pre[i].valid) fr = i;
    end
    for (int i = 0; i < RS; i++) begin
      if (pre[i].valid) begin
        resolve(pre[i].d1, pre[i].v1, td, tv); nx[i].d1 = td; nx[i].v1 = tv;
        resolve(pre[i].d2, pre[i].v2, td, tv); nx[i].d2 = td; nx[i].v2 = tv;
      end
    end
    if (sel >= 0) begin
      m_en  <= 1'b1;
      m_op  <= pre[sel].op;
      m_v1  <= pre[sel].v1;
      m_v2  <= pre[sel].v2;
      m_imm <= pre[sel].imm;
      m_pc  <= pre[sel].pc;
      m_rob <= pre[sel].rob;
      m_pbr <= pre[sel].pbr;
      nx[sel].valid = 1'b0;
    end else begin
      m_en <= 1'b0;
    end
    if (iss) begin
      n_total++;
      if (fr >= 0) begin
        n_pass++;
        nx[fr].valid = 1'b1;
        nx[fr].op    = iss_op;
        nx[fr].imm   = iss_imm;
        nx[fr].pc    = iss_pc;
        nx[fr].rob   = iss_rob;
        nx[fr].pbr   = iss_pbr;
        resolve(iss_d1, iss_v1, td, tv); nx[fr].d1 = td; nx[fr].v1 = tv;
        resolve(iss_d2, iss_v2, td, tv); nx[fr].d2 = td; nx[fr].v2 = tv;
      end else begin
        $display("FAIL protocol_issue_no_free_slot: got issue with occupancy %0d, expected no issue at t=%0t",
                 occupancy(), $time);
      end
    end
    m <= nx;
  endtask

  // Model state advance, with asynchronous reset like the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS; i++) m[i] <= '{default: '0};
      m_en  <= 1'b0;
      m_op  <= '0;
      m_v1  <= '0;
      m_v2  <= '0;
      m_imm <= '0;
      m_pc  <= '0;
      m_rob <= '0;
      m_pbr <= 1'b0;
    end else begin
      model_edge();
    end
  end

  // Per-cycle compare of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (run && !rst) begin
      chk("cmp_full", d_full, (occupancy() >= RS - 1) ? 1 : 0);
      chk("cmp_en",   d_en,   m_en);
      chk("cmp_op",   d_op,   m_op);
      chk("cmp_rs1",  d_v1,   m_v1);
      chk("cmp_rs2",  d_v2,   m_v2);
      chk("cmp_imm",  d_imm,  m_imm);
      chk("cmp_pc",   d_pc,   m_pc);
      chk("cmp_rob",  d_rob,  m_rob);
      chk("cmp_pbr",  d_pbr,  m_pbr);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    iss     = 1'b0;
    alu_rdy = 1'b0;
    lsb_rdy = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] v1, input logic [3:0] d1,
                       input logic [31:0] v2, input logic [3:0] d2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [3:0] rob, input logic pbr);
    iss     = 1'b1;
    iss_op  = op;
    iss_v1  = v1;
    iss_d1  = d1;
    iss_v2  = v2;
    iss_d2  = d2;
    iss_imm = imm;
    iss_pc  = pc;
    iss_rob = rob;
    iss_pbr = pbr;
  endtask

  task automatic alu_bcast(input logic [3:0] tag, input logic [31:0] res);
    alu_rdy = 1'b1;
    alu_tag = tag;
    alu_res = res;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    @(negedge clk);
    chk("reset_en",   d_en,   0);
    chk("reset_full", d_full, 0);
    chk("reset_rs1",  d_v1,   0);
    chk("reset_rob",  d_rob,  0);
    rst = 1'b0;
    run = 1'b1;

    // Single ready ADDI: dispatched one edge after insertion.
    issue(OPENUM_ADDI, 32'd5, 4'd0, 32'd0, 4'd0, 32'd3, 32'h100, 4'd2, 1'b0);
    step();
    chk("t1_not_same_cycle", d_en, 0);
    idle();
    step();
    chk("t1_en",  d_en,  1);
    chk("t1_op",  d_op,  OPENUM_ADDI);
    chk("t1_rs1", d_v1,  5);
    chk("t1_imm", d_imm, 3);
    chk("t1_rob", d_rob, 2);
    chk("t1_model_count", occupancy(), 0);
    step();
    chk("t1_pulse_ends", d_en, 0);

    // ALU wakeup of rs1 on a later edge.
    issue(OPENUM_ADD, 32'd0, 4'd7, 32'd9, 4'd0, 32'd0, 32'h104, 4'd4, 1'b0);
    step();
    idle();
    step();
    chk("t2_waiting", d_en, 0);
    alu_bcast(4'd7, 32'h1234);
    step();
    chk("t2_wake_edge_no_dispatch", d_en, 0);
    idle();
    step();
    chk("t2_en",  d_en, 1);
    chk("t2_rs1", d_v1, 32'h1234);
    chk("t2_rs2", d_v2, 9);
    chk("t2_rob", d_rob, 4);

    // Operand resolved at insertion by a same-cycle LSB broadcast.
    issue(OPENUM_ADDI, 32'd0, 4'd3, 32'd0, 4'd0, 32'd1, 32'h108, 4'd6, 1'b0);
    lsb_rdy = 1'b1;
    lsb_tag = 4'd3;
    lsb_res = 32'hAA;
    step();
    idle();
    step();
    chk("t3_en",  d_en, 1);
    chk("t3_rs1", d_v1, 32'hAA);
    chk("t3_rob", d_rob, 6);

    // Fill all 16 slots dependent on tag 5, then release them in slot order.
    for (int i = 0; i < RS; i++) begin
      issue(OPENUM_ADD, 32'd0, 4'd5, 32'(i), 4'd0, 32'd0, 32'h200 + 32'(4 * i), 4'((i % 15) + 1), 1'b0);
      step();
      if (i == 13) chk("t4_full_at_14", d_full, 0);
      if (i == 14) chk("t4_full_at_15", d_full, 1);
    end
    idle();
    chk("t4_model_count_16", occupancy(), 16);
    alu_bcast(4'd5, 32'h55);
    step();
    chk("t4_wake_edge_no_dispatch", d_en, 0);
    idle();
    for (int k = 0; k < RS; k++) begin
      step();
      chk("t4_en",    d_en, 1);
      chk("t4_order", d_v2, 32'(k));
      chk("t4_rs1",   d_v1, 32'h55);
      if (k == 0) chk("t4_full_at_15_drain", d_full, 1);
      if (k == 1) chk("t4_full_falls_at_14", d_full, 0);
    end
    step();
    chk("t4_drained", d_en, 0);

    // Leave slots 0,1,3 occupied (slot 2 dispatches), then flush.
    issue(OPENUM_ADD, 32'd0, 4'd9, 32'hA, 4'd0, 32'd0, 32'h300, 4'd1, 1'b0);
    step();
    issue(OPENUM_ADD, 32'd0, 4'd9, 32'hB, 4'd0, 32'd0, 32'h304, 4'd2, 1'b0);
    step();
    issue(OPENUM_SUB, 32'd1, 4'd0, 32'hC, 4'd0, 32'd0, 32'h308, 4'd3, 1'b0);
    step();
    issue(OPENUM_ADD, 32'd0, 4'd9, 32'hD, 4'd0, 32'd0, 32'h30C, 4'd4, 1'b0);
    step();
    chk("t5_c_dispatched", d_v2, 32'hC);
    chk("t5_model_count_3", occupancy(), 3);
    issue(OPENUM_ADDI, 32'd2, 4'd0, 32'd0, 4'd0, 32'd0, 32'h310, 4'd5, 1'b0);
    alu_bcast(4'd9, 32'h99);
    clr = 1'b1;
    step();
    chk("t5_clr_en",   d_en,   0);
    chk("t5_clr_full", d_full, 0);
    chk("t5_model_count_0", occupancy(), 0);
    idle();
    alu_bcast(4'd9, 32'h99);
    step();
    chk("t5_no_dispatch_a", d_en, 0);
    idle();
    step();
    chk("t5_no_dispatch_b", d_en, 0);

    // Global hold with a ready entry resident.
    issue(OPENUM_LUI, 32'h77, 4'd0, 32'd0, 4'd0, 32'h1000, 32'h400, 4'd5, 1'b1);
    step();
    idle();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_hold_no_dispatch", d_en, 0);
    end
    rdy = 1'b1;
    step();
    chk("t6_en",  d_en,  1);
    chk("t6_rs1", d_v1,  32'h77);
    chk("t6_imm", d_imm, 32'h1000);
    chk("t6_pbr", d_pbr, 1);

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_en",   d_en,   0);
    chk("t6_async_rs1",  d_v1,  0);
    chk("t6_async_imm",  d_imm, 0);
    chk("t6_async_rob",  d_rob, 0);
    chk("t6_async_full", d_full, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("t6_after_reset", d_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
